// File: rtl/timer_sched.sv
// Round-robin multi-channel interval timer: latches expiries as pending events and presents one per irq/ack.
// Latency: expiry -> pending same edge -> irq next edge; irq is held until irq_ack, then low for at least one cycle.
module timer_sched #(
  parameter int BITS     = 32,
  parameter int CHANNELS = 4,
  parameter int CHAN_W   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [BITS-1:0]     cfg_period,
  input  logic                cfg_enable,
  input  logic                cfg_periodic,
  output logic                irq,
  output logic [CHAN_W-1:0]   irq_chan,
  input  logic                irq_ack,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] overrun,
  output logic [CHANNELS-1:0] active
);

  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_nxt;

  logic [BITS-1:0]     count  [CHANNELS];
  logic [BITS-1:0]     period [CHANNELS];
  logic [CHANNELS-1:0] periodic;
  logic [CHANNELS-1:0] wr_hit, expire, ack_clr;
  logic [CHAN_W-1:0]   rr_ptr, sel_chan;
  logic [CHAN_W:0]     idx;
  logic                sel_vld, ack_vld;

  assign ack_vld = (state == PRESENT) && irq_ack;

  // A config write to a channel suppresses that channel's expiry in the same cycle.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      wr_hit[c]  = cfg_we && (cfg_chan == CHAN_W'(c));
      expire[c]  = active[c] && (count[c] == period[c]) && !wr_hit[c];
      ack_clr[c] = ack_vld && (irq_chan == CHAN_W'(c));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        count[c]  <= '0;
        period[c] <= '0;
      end
      active   <= '0;
      periodic <= '0;
      pending  <= '0;
      overrun  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_hit[c]) begin
          count[c]    <= '0;
          period[c]   <= cfg_period;
          active[c]   <= cfg_enable;
          periodic[c] <= cfg_periodic;
        end else if (active[c]) begin
          if (count[c] == period[c]) begin
            count[c] <= '0;
            if (!periodic[c]) active[c] <= 1'b0;
          end else begin
            count[c] <= count[c] + 1'b1;
          end
        end
        // A new expiry beats a same-cycle ack; overrun only marks events that are actually lost.
        pending[c] <= expire[c] | (pending[c] & ~ack_clr[c]);
        if (wr_hit[c])
          overrun[c] <= 1'b0;
        else if (expire[c] && pending[c] && !ack_clr[c])
          overrun[c] <= 1'b1;
      end
    end
  end

  // First pending channel at or after rr_ptr, wrapping modulo CHANNELS.
  always_comb begin
    sel_vld  = 1'b0;
    sel_chan = '0;
    idx      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = {1'b0, rr_ptr} + (CHAN_W+1)'(i);
      if (idx >= (CHAN_W+1)'(CHANNELS)) idx = idx - (CHAN_W+1)'(CHANNELS);
      if (!sel_vld && pending[idx[CHAN_W-1:0]]) begin
        sel_vld  = 1'b1;
        sel_chan = idx[CHAN_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      irq_chan <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_vld) irq_chan <= sel_chan;
      if (ack_vld) rr_ptr <= (irq_chan == CHAN_W'(CHANNELS-1)) ? '0 : irq_chan + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_vld) state_nxt = PRESENT;
      PRESENT: if (irq_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    irq = (state == PRESENT);
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: expected presentations are queued as expiries are predicted
// and popped when irq is observed; all other values are cycle-exact constants.
module tb_timer_sched;
  localparam int BITS = 32, CHANNELS = 4, CHAN_W = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                cfg_we;
  logic [CHAN_W-1:0]   cfg_chan;
  logic [BITS-1:0]     cfg_period;
  logic                cfg_enable;
  logic                cfg_periodic;
  logic                irq;
  logic [CHAN_W-1:0]   irq_chan;
  logic                irq_ack;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] overrun;
  logic [CHANNELS-1:0] active;

  int checks = 0;
  int passed = 0;
  logic [CHAN_W-1:0] sb[$];

  always #5 clock = ~clock;

  timer_sched #(.BITS(BITS), .CHANNELS(CHANNELS), .CHAN_W(CHAN_W)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_period(cfg_period), .cfg_enable(cfg_enable), .cfg_periodic(cfg_periodic),
    .irq(irq), .irq_chan(irq_chan), .irq_ack(irq_ack),
    .pending(pending), .overrun(overrun), .active(active)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int ch, input int per, input bit en, input bit pdc);
    cfg_chan     = CHAN_W'(ch);
    cfg_period   = BITS'(per);
    cfg_enable   = en;
    cfg_periodic = pdc;
    cfg_we       = 1'b1;
    tick();
    cfg_we       = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [CHAN_W-1:0] exp_chan;
    exp_chan = 'x;
    if (sb.size() > 0) exp_chan = sb.pop_front();
    check(tag, irq_chan, exp_chan);
  endtask

  // Wait (bounded) for irq, compare the presented channel against the scoreboard, then acknowledge.
  task automatic service(input string tag, input int exp_wait);
    int w;
    logic [CHAN_W-1:0] ch;
    w = 0;
    while (irq !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check({tag, "_irq"}, irq, 1);
    if (exp_wait >= 0) check({tag, "_gap"}, w, exp_wait);
    ch = irq_chan;
    pop_check({tag, "_chan"});
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check({tag, "_ack_irq"}, irq, 0);
    check({tag, "_ack_pend"}, pending[ch], 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d passed=%0d)", checks, passed);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic quiet;

    reset = 1'b1; cfg_we = 1'b0; cfg_chan = '0; cfg_period = '0;
    cfg_enable = 1'b0; cfg_periodic = 1'b0; irq_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_irq", irq, 0);
    check("rst_chan", irq_chan, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    check("rst_active", active, 0);

    // Periodic ch0, period 3: expiries on edges 4, 8, 12 after the write.
    cfg(0, 3, 1'b1, 1'b1);
    check("t1_active", active[0], 1);
    e = 0;
    for (int k = 1; k <= 3; k++) begin
      while (e < 4*k - 1) begin tick(); e++; end
      check("t1_pre", pending[0], 0);
      tick(); e++;
      check("t1_pend", pending[0], 1);
      check("t1_irq_lag", irq, 0);
      sb.push_back(2'd0);
      tick(); e++;
      check("t1_irq", irq, 1);
      pop_check("t1_chan");
      irq_ack = 1'b1; tick(); irq_ack = 1'b0; e++;
      check("t1_ack_irq", irq, 0);
      check("t1_ack_pend", pending[0], 0);
    end
    cfg(0, 3, 1'b0, 1'b0);

    // One-shot ch1, period 2.
    cfg(1, 2, 1'b1, 1'b0);
    tick(); tick();
    check("t2_pre", pending[1], 0);
    tick();
    check("t2_pend", pending[1], 1);
    check("t2_oneshot", active[1], 0);
    sb.push_back(2'd1);
    service("t2", 1);
    quiet = 1'b0;
    repeat (20) begin tick(); quiet = quiet | pending[1] | irq; end
    check("t2_quiet", quiet, 0);

    // Round-robin order from pointer 0, then wrap from pointer 3.
    reset = 1'b1; tick(); reset = 1'b0;
    cfg(0, 0, 1'b1, 1'b0);
    cfg(1, 0, 1'b1, 1'b0);
    cfg(2, 0, 1'b1, 1'b0);
    sb.push_back(2'd0); sb.push_back(2'd1); sb.push_back(2'd2);
    service("t3a", 0);
    service("t3b", 1);
    service("t3c", 1);
    cfg(2, 1, 1'b1, 1'b0);
    cfg(0, 0, 1'b1, 1'b0);
    sb.push_back(2'd0); sb.push_back(2'd2);
    service("t3w0", 2);
    service("t3w2", 1);

    // Period 0 with no ack: overrun from the second expiry; a write clears overrun only.
    cfg(0, 0, 1'b1, 1'b1);
    tick();
    check("t4_pend1", pending[0], 1);
    check("t4_ovr1", overrun[0], 0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("t4_pend_ovr", {pending[0], overrun[0]}, 2'b11);
    end
    cfg(0, 5, 1'b1, 1'b1);
    check("t4_wr_ovr", overrun[0], 0);
    check("t4_wr_pend", pending[0], 1);
    check("t4_wr_irq", irq, 1);
    check("t4_wr_chan", irq_chan, 0);
    sb.push_back(2'd0);
    service("t4", 0);
    cfg(0, 0, 1'b0, 1'b0);

    // Ack on the same edge as a new expiry of the presented channel.
    cfg(0, 3, 1'b1, 1'b1);
    sb.push_back(2'd0);
    repeat (5) tick();
    check("t5_irq", irq, 1);
    pop_check("t5_chan");
    tick(); tick();
    check("t5_hold_irq", irq, 1);
    check("t5_hold_chan", irq_chan, 0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t5_coll_irq", irq, 0);
    check("t5_coll_pend", pending[0], 1);
    check("t5_coll_ovr", overrun[0], 0);
    sb.push_back(2'd0);
    service("t5b", 1);
    cfg(0, 3, 1'b0, 1'b0);

    // Reset while presenting, with a config write that reset must override.
    cfg(1, 2, 1'b1, 1'b1);
    cfg(2, 100, 1'b1, 1'b1);
    repeat (4) tick();
    check("t6_pre_irq", irq, 1);
    check("t6_pre_chan", irq_chan, 1);
    reset = 1'b1;
    cfg_chan = 2'd3; cfg_period = 32'd5; cfg_enable = 1'b1; cfg_periodic = 1'b1; cfg_we = 1'b1;
    tick();
    reset = 1'b0; cfg_we = 1'b0;
    check("t6_irq", irq, 0);
    check("t6_chan", irq_chan, 0);
    check("t6_pending", pending, 0);
    check("t6_overrun", overrun, 0);
    check("t6_active", active, 0);
    quiet = 1'b0;
    repeat (10) begin tick(); quiet = quiet | irq | (|pending) | (|active); end
    check("t6_quiet", quiet, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
